ps2_kbd_rx_fifo: RTL

Parametrised PS/2 keyboard receiver. It deserialises device-to-host frames, validates start, parity and stop bits, and folds the E0/F0 prefix bytes into one key event per scan code. Events are buffered in a FIFO and handed to the consumer over a valid/ready interface. It replaces the single-register, ready-pulse receiver in the NPC peripheral path and adds overflow reporting, error counting and a frame timeout.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_evt_fifo.sv | 55 +++++
 rtl/ps2_kbd_rx_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the prefix bytes, frame FSM states and the key event bundle.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_st_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO for the PS/2 receiver.
// Head data reads zero while empty so idle outputs stay quiet.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  ps2_evt_t               i_data,
  input  logic                   i_pop,
  output ps2_evt_t               o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix folding,
// buffered key events with overflow flag and error counter.
module ps2_kbd_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ERR_W       = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_code,
  output logic                          out_break,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [ERR_W-1:0]              err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  ps2_st_e                r_state;
  ps2_st_e                w_state_nxt;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_tcnt;
  logic                   r_fv;
  logic                   r_fb;
  logic                   r_ext;
  logic                   r_brk;
  logic                   r_ovf;
  logic [ERR_W-1:0]       r_err;

  logic                   w_edge;
  logic                   w_data;
  logic                   w_tout;
  logic                   w_frm_ok;
  logic                   w_frm_bad;
  logic                   w_prefix;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  ps2_evt_t               w_evt;
  ps2_evt_t               w_head;

  assign w_edge = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_data = r_dat_sync[SYNC_STAGES-2];
  assign w_tout = (r_state != IDLE) & ~w_edge
                & (r_tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frm_ok    = 1'b0;
    w_frm_bad   = 1'b0;
    unique case (r_state)
      IDLE:   if (w_edge && !w_data) w_state_nxt = DATA;
      DATA:   if (w_edge && r_cnt == 3'd7) w_state_nxt = PARITY;
      PARITY: if (w_edge) w_state_nxt = STOP;
      STOP: begin
        if (w_edge) begin
          w_state_nxt = IDLE;
          w_frm_ok    = w_data & (^{r_shift, r_par});
          w_frm_bad   = ~w_frm_ok;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_tout) begin
      w_state_nxt = IDLE;
      w_frm_bad   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_fv    <= 1'b0;
      r_fb    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fv    <= w_frm_ok;
      r_fb    <= w_frm_bad;
      if (w_edge || r_state == IDLE || w_tout) r_tcnt <= '0;
      else                                      r_tcnt <= r_tcnt + 1'b1;
      if (w_edge) begin
        unique case (r_state)
          IDLE: r_cnt <= '0;
          DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            r_cnt   <= r_cnt + 1'b1;
          end
          PARITY:  r_par <= w_data;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // r_shift still holds the byte in the cycle after the stop edge
  assign w_prefix = (r_shift == PS2_EXT) | (r_shift == PS2_BRK);
  assign w_push   = r_fv & ~w_prefix;
  assign w_evt    = '{ext: r_ext, brk: r_brk, code: r_shift};
  assign w_pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_err <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_fb) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (r_err != '1) r_err <= r_err + 1'b1;
      end else if (r_fv) begin
        unique case (1'b1)
          r_shift == PS2_EXT: r_ext <= 1'b1;
          r_shift == PS2_BRK: r_brk <= 1'b1;
          default: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
        endcase
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (overflow_clr)          r_ovf <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign out_valid = ~w_empty;
  assign out_code  = w_head.code;
  assign out_break = w_head.brk;
  assign out_ext   = w_head.ext;
  assign overflow  = r_ovf;
  assign err_count = r_err;

endmodule
